// File: rtl/cmp_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cmp_sweep_ctrl
// Brief    : Exhaustive self-check sequencer for a W-bit magnitude comparator.
// Revision : 1.0
// ============================================================================
module cmp_sweep_ctrl #(
    parameter int W      = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    input  logic             gt_in,
    input  logic             eq_in,
    input  logic             lt_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*W:0]     err_count,
    output logic             first_fail_valid,
    output logic [2*W-1:0]   first_fail_vec
);

    localparam int c_VEC_W = 2 * W;
    localparam int c_ERR_W = 2 * W + 1;
    localparam int c_CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(SETTLE - 1);
    localparam logic [c_VEC_W-1:0] c_VEC_LAST = {c_VEC_W{1'b1}};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]         r_state, w_state_nxt;
    logic [c_VEC_W-1:0] r_vec,   w_vec_nxt;
    logic [c_CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [c_ERR_W-1:0] r_err,   w_err_nxt;
    logic               r_ffv,   w_ffv_nxt;
    logic [c_VEC_W-1:0] r_ffvec, w_ffvec_nxt;

    logic [W-1:0]       w_a;
    logic [W-1:0]       w_b;
    logic [2:0]         w_expect;
    logic               w_mismatch;

    assign w_a        = r_vec[c_VEC_W-1:W];
    assign w_b        = r_vec[W-1:0];
    assign w_expect   = {w_a > w_b, w_a == w_b, w_a < w_b};
    // Exact compare against the one-hot truth also rejects zero/multi-hot answers.
    assign w_mismatch = ({gt_in, eq_in, lt_in} != w_expect);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_ffv   <= w_ffv_nxt;
            r_ffvec <= w_ffvec_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_ffv_nxt   = r_ffv;
        w_ffvec_nxt = r_ffvec;
        // Abort freezes every result register; only the state is forced.
        if (abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        w_state_nxt = c_WAIT;
                        w_vec_nxt   = '0;
                        w_cnt_nxt   = c_CNT_LOAD;
                        w_err_nxt   = '0;
                        w_ffv_nxt   = 1'b0;
                        w_ffvec_nxt = '0;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_CHECK;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                    end
                end
                c_CHECK: begin
                    if (w_mismatch) begin
                        w_err_nxt = r_err + c_ERR_W'(1);
                        if (!r_ffv) begin
                            w_ffv_nxt   = 1'b1;
                            w_ffvec_nxt = r_vec;
                        end
                    end
                    if (r_vec == c_VEC_LAST) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_WAIT;
                        w_vec_nxt   = r_vec + c_VEC_W'(1);
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    assign a_out            = w_a;
    assign b_out            = w_b;
    assign busy             = (r_state == c_WAIT) || (r_state == c_CHECK);
    assign done             = (r_state == c_DONE);
    assign pass             = done && (r_err == '0);
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;

endmodule
`default_nettype wire

// File: tb/tb_cmp_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_sweep_ctrl
// Brief    : Self-checking bench for cmp_sweep_ctrl with a cycle-level model.
// Revision : 1.0
// ============================================================================
module tb_cmp_sweep_ctrl;

    localparam int W   = 3;
    localparam int N   = 2 * W;
    localparam int S   = 1;
    localparam int MAX = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [W-1:0] a_out, b_out;
    logic         gt_in, eq_in, lt_in;
    logic         busy, done, pass;
    logic [N:0]   err_count;
    logic         first_fail_valid;
    logic [N-1:0] first_fail_vec;

    logic         start3;
    logic         abort3;
    logic [W-1:0] a3, b3;
    logic         gt3, eq3, lt3;
    logic         busy3, done3, pass3;
    logic [N:0]   err3;
    logic         ffv3;
    logic [N-1:0] ffvec3;

    int           mode;
    logic [3:0]   rnd;
    logic [N-1:0] ab_d1, ab_d2, ab3_d1, ab3_d2;
    logic [2:0]   resp;

    int           n_pass;
    int           n_total;
    logic         chk_on;

    always #5 clk = ~clk;

    cmp_sweep_ctrl #(.W(W), .SETTLE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_out(a_out), .b_out(b_out),
        .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
    );

    cmp_sweep_ctrl #(.W(W), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .a_out(a3), .b_out(b3),
        .gt_in(gt3), .eq_in(eq3), .lt_in(lt3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
    );

    function automatic logic [2:0] truth(input logic [N-1:0] v);
        int a, b;
        a = int'(v) >> W;
        b = int'(v) % (1 << W);
        return {a > b, a == b, a < b};
    endfunction

    // Comparator models: 0 good, 1 gt stuck low, 2 gt/eq stuck high,
    // 3 response lags operands by two cycles, 4 random garbage half the time.
    always @(posedge clk) begin
        rnd    <= 4'($urandom);
        ab_d1  <= {a_out, b_out};
        ab_d2  <= ab_d1;
        ab3_d1 <= {a3, b3};
        ab3_d2 <= ab3_d1;
    end

    always_comb begin
        resp = truth({a_out, b_out});
        case (mode)
            1: resp[2] = 1'b0;
            2: resp[2:1] = 2'b11;
            3: resp = truth(ab_d2);
            4: if (rnd[3]) resp = rnd[2:0];
            default: ;
        endcase
    end
    assign {gt_in, eq_in, lt_in} = resp;
    assign {gt3, eq3, lt3}       = truth(ab3_d2);

    // Reference model: cycles since start decide which vector is presented
    // and whether the comparator is being judged this cycle.
    logic         m_run, m_done, m_ffv;
    int           m_k;
    logic [N-1:0] m_vec, m_ffvec;
    logic [N:0]   m_err;

    always @(posedge clk or negedge rst_n) begin : model
        logic         run, dn, fv;
        int           k;
        logic [N-1:0] v, fvec;
        logic [N:0]   e;
        if (!rst_n) begin
            m_run <= 1'b0; m_done <= 1'b0; m_k <= 0; m_vec <= '0;
            m_err <= '0; m_ffv <= 1'b0; m_ffvec <= '0;
        end else begin
            run = m_run; dn = m_done; k = m_k; v = m_vec;
            e = m_err; fv = m_ffv; fvec = m_ffvec;
            if (abort) begin
                run = 1'b0; dn = 1'b0;
            end else if (!run && start) begin
                run = 1'b1; dn = 1'b0; k = 0; v = '0;
                e = '0; fv = 1'b0; fvec = '0;
            end else if (run) begin
                if (k % (S + 1) == S) begin
                    if ({gt_in, eq_in, lt_in} != truth(v)) begin
                        e = e + 1;
                        if (!fv) begin fv = 1'b1; fvec = v; end
                    end
                    if (int'(v) == MAX) begin run = 1'b0; dn = 1'b1; end
                end
                k = k + 1;
                if (run) v = N'(k / (S + 1));
            end
            m_run <= run; m_done <= dn; m_k <= k; m_vec <= v;
            m_err <= e; m_ffv <= fv; m_ffvec <= fvec;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cycle_compare();
        n_total++;
        if ({a_out, b_out} !== m_vec || busy !== m_run || done !== m_done ||
            pass !== (m_done && m_err == 0) || err_count !== m_err ||
            first_fail_valid !== m_ffv || first_fail_vec !== m_ffvec) begin
            $display("FAIL cycle t=%0t got/exp: vec %0d/%0d busy %0b/%0b done %0b/%0b pass %0b/%0b err %0d/%0d ffv %0b/%0b ffvec %0d/%0d",
                     $time, {a_out, b_out}, m_vec, busy, m_run, done, m_done,
                     pass, (m_done && m_err == 0), err_count, m_err,
                     first_fail_valid, m_ffv, first_fail_vec, m_ffvec);
        end else begin
            n_pass++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_vec(input int target);
        int n;
        n = 0;
        while (!(busy && int'({a_out, b_out}) == target) && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) chk("vec_timeout", int'({a_out, b_out}), target);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a"}, int'(a_out), 0);
        chk({tag, "_b"}, int'(b_out), 0);
        chk({tag, "_busy_done_pass"}, int'({busy, done, pass}), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_ffv"}, int'(first_fail_valid), 0);
        chk({tag, "_ffvec"}, int'(first_fail_vec), 0);
    endtask

    initial begin
        int n;
        n_pass = 0; n_total = 0; chk_on = 1'b0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; mode = 0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk); rst_n = 1'b1; chk_on = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (chk_on && rst_n) cycle_compare();
            end
        join_none

        // Good comparator
        mode = 0;
        pulse_start();
        wait_done(n);
        chk("good_latency", n, 128);
        chk("good_err", int'(err_count), 0);
        chk("good_pass", int'(pass), 1);
        chk("good_ffv", int'(first_fail_valid), 0);

        // gt stuck low: every A>B pair fails
        mode = 1;
        pulse_start();
        wait_done(n);
        chk("gt0_err", int'(err_count), 28);
        chk("gt0_ffvec", int'(first_fail_vec), 8);
        chk("gt0_pass", int'(pass), 0);

        // gt and eq stuck high: nothing is one-hot correct
        mode = 2;
        pulse_start();
        wait_done(n);
        chk("gteq_err", int'(err_count), 64);
        chk("gteq_ffvec", int'(first_fail_vec), 0);
        chk("gteq_ffv", int'(first_fail_valid), 1);

        // Slow comparator with too short a settle interval
        mode = 3;
        pulse_start();
        wait_done(n);
        chk("slow_s1_errs_seen", int'(err_count > 0), 1);

        // Same slow comparator against the SETTLE=3 instance
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        n = 0;
        while (!done3 && n < 3000) begin @(negedge clk); n++; end
        chk("slow_s3_latency", n, 256);
        chk("slow_s3_err", int'(err3), 0);
        chk("slow_s3_pass", int'(pass3), 1);

        // Abort at vector 20
        mode = 1;
        pulse_start();
        wait_vec(20);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy_done", int'({busy, done}), 0);
        chk("abort_a", int'(a_out), 2);
        chk("abort_b", int'(b_out), 4);
        chk("abort_err_kept", int'(err_count), 3);
        pulse_start();
        chk("restart_err", int'(err_count), 0);
        chk("restart_vec", int'({a_out, b_out}), 0);

        // start while busy is ignored, then async reset at vector 40
        @(negedge clk); start = 1'b1;
        @(negedge clk); @(negedge clk); start = 1'b0;
        wait_vec(40);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        #1 rst_n = 1'b1;

        // start and abort together in IDLE
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_done", int'(done), 0);

        // Randomised sweeps with stray starts and random aborts
        for (int it = 0; it < 10; it++) begin
            int len;
            mode = $urandom_range(0, 4);
            pulse_start();
            len = $urandom_range(0, 200);
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                start = ($urandom_range(0, 40) == 0);
            end
            start = 1'b0;
            if (!done && $urandom_range(0, 1) == 1) begin
                @(negedge clk); abort = 1'b1;
                @(negedge clk); abort = 1'b0;
            end else if (busy) begin
                wait_done(n);
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmp_sweep_ctrl.md
Name: cmp_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises an attached W-bit magnitude comparator (3-bit comparator by default).
- Walks every {A,B} operand pair in ascending order, waits a settle interval, then checks gt/eq/lt against the arithmetic truth.
- Accumulates a mismatch count and captures the first failing vector.
- Sits between a start/status interface and the comparator datapath, replacing hand-enumerated stimulus with an on-chip self-check.

Parameters:
- W, 3, operand width; vector space is 2^(2W).
- SETTLE, 1, cycles the operands are held before sampling; legal range >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sweep; sampled in IDLE or DONE only.
- abort  input  1  terminate sweep, return to IDLE.
- a_out  output  W  operand A to comparator.
- b_out  output  W  operand B to comparator.
- gt_in  input  1  comparator A>B result.
- eq_in  input  1  comparator A==B result.
- lt_in  input  1  comparator A<B result.
- busy  output  1  high in WAIT and CHECK.
- done  output  1  high in DONE.
- pass  output  1  done && err_count==0.
- err_count  output  2W+1  mismatching vectors in the current or last sweep.
- first_fail_valid  output  1  a failing vector has been captured.
- first_fail_vec  output  2W  {A,B} of the first failing vector.

Behaviour:
- Vector encoding:
  - vec[2W-1:0], with a_out = vec[2W-1:W] and b_out = vec[W-1:0].
  - The A MSB is the most significant bit of vec; sweep order is 0 .. 2^(2W)-1.
- Reset (async, rst_n=0):
  - State IDLE; vec=0, so a_out=b_out=0.
  - busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, settle counter=0.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - Outputs hold vec.
  - start=1 → vec<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, cnt<=SETTLE-1, go to WAIT.
- WAIT:
  - a_out/b_out driven from vec.
  - cnt==0 → CHECK; else cnt<=cnt-1.
  - Occupies exactly SETTLE cycles per vector.
- CHECK (one cycle, operands unchanged):
  - expected = {A>B, A==B, A<B}, unsigned compare.
  - Mismatch when {gt_in,eq_in,lt_in} != expected; non-one-hot or all-zero responses are always mismatches.
  - On mismatch: err_count<=err_count+1. If !first_fail_valid, capture first_fail_vec<=vec and set first_fail_valid<=1.
  - If vec==2^(2W)-1 → DONE; else vec<=vec+1, cnt<=SETTLE-1, go to WAIT.
- DONE:
  - vec holds last value; done=1; counters frozen.
  - start=1 → restart exactly as from IDLE.
- Latency: start sampled at edge 0 → done high after 2^(2W)*(SETTLE+1) cycles. Default: 128 cycles.
- err_count never overflows, since its max of 2^(2W) fits in 2W+1 bits; no saturation logic.
- start while busy: ignored.
- abort:
  - In any state → IDLE next edge; done=0; err_count/first_fail fields retained, vec retained.
  - abort and start asserted together: abort wins.
- Comparator inputs are sampled only in CHECK; glitches in WAIT have no effect.
- rst_n deasserted mid-sweep: immediate IDLE with all reset values; no partial results preserved.

Test Plan:
- Correct comparator model, W=3, SETTLE=1, pulse start → done rises 128 cycles later; err_count=0, pass=1, first_fail_valid=0; a_out/b_out step 0..7 across the sweep in the given order.
- gt_in stuck at 0 → err_count=28 (count of A>B pairs), first_fail_vec=6'b001000 (A=1,B=0), pass=0.
- eq_in and gt_in both forced 1 → every vector fails, err_count=64, first_fail_vec=0.
- SETTLE=3 with a model whose outputs update 2 cycles after the operands → err_count=0, done after 256 cycles. The same model with SETTLE=1 → err_count>0.
- Abort when vec=20 → IDLE next cycle, busy=0, done=0, a_out/b_out hold {2,4}. A subsequent start clears err_count and restarts from vec 0.
- rst_n pulsed low mid-sweep (vec=40) → outputs return to reset values asynchronously; start ignored while busy; start with abort simultaneously in IDLE → stays IDLE.
